uart_cmd_decoder: RTL
=====================

# uart_cmd_decoder

Converts received UART bytes into the command pulses and mode-toggle levels consumed by the watch/stopwatch control unit, and echoes an acknowledgement byte for every received byte back out through the UART transmitter. It sits between `uart_rx` and the control unit on the command path, and between itself and `uart_tx` on the echo path. A 4-entry echo FIFO decouples bursts of received bytes from the slower transmit side.

## Interface
- Parameters:
- `ECHO_DEPTH`, default 4: echo FIFO entries; must be a power of two.
- Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `rx_data`  in  8  received byte; valid only when `rx_done`=1.
- `rx_done`  in  1  one-cycle strobe from `uart_rx`.
- `tx_done`  in  1  one-cycle strobe from `uart_tx` at the end of a frame.
- `tx_start`  out  1  one-cycle transmit request.
- `tx_data`  out  8  byte to transmit; held stable from `tx_start` until `tx_done`.
- `ascii_d`  out  5  one-cycle command pulses: [0] run/stop, [1] clear, [2] up, [3] down, [4] next.
- `ascii_up_down`, `ascii_stopwatch_watch`, `ascii_hm_sms`, `ascii_watch_set`, `ascii_humi_temp`  out  1 each  mode toggle levels.
- `echo_ovf`  out  1  sticky flag: at least one echo was dropped.

## Operation
- Case folding: bytes 0x61–0x7A have 0x20 subtracted before decode.
- Pulse commands:
  - 'R' (0x52) → `ascii_d[0]`
  - 'C' (0x43) → `ascii_d[1]`
  - 'U' (0x55) → `ascii_d[2]`
  - 'D' (0x44) → `ascii_d[3]`
  - 'N' (0x4E) → `ascii_d[4]`
- Toggle commands invert the corresponding level:
  - 'M' (0x4D) → `ascii_up_down`
  - 'W' (0x57) → `ascii_stopwatch_watch`
  - 'H' (0x48) → `ascii_hm_sms`
  - 'T' (0x54) → `ascii_watch_set`
  - 'P' (0x50) → `ascii_humi_temp`
- Echo content:
  - Valid command: echoes the folded uppercase byte.
  - Any other byte: no pulse and no toggle; echoes '?' (0x3F).
- Echo FIFO: circular, `log2(ECHO_DEPTH)`-bit pointers with wrap, plus a count register.
  - Push on a decode cycle.
  - Pop when the TX FSM loads a byte.
- TX FSM has two states:
  - IDLE: when the FIFO is non-empty, pop the head into `tx_data`, drive `tx_start`=1 for one cycle, go to BUSY.
  - BUSY: wait for `tx_done`, then go to IDLE.
- Reset values: `ascii_d`=0, all toggle levels=0, `tx_start`=0, `tx_data`=0x00, `echo_ovf`=0, FIFO empty, FSM=IDLE.

## Timing
- `rx_done` in cycle n:
  - The pulse, toggle and FIFO push all happen in cycle n+1; `ascii_d` is high for exactly cycle n+1.
  - With an empty FIFO and an idle FSM, `tx_start` rises in n+2.
- Back-to-back `rx_done` strobes in consecutive cycles are each decoded; no byte is lost on the command side.
- FIFO full when a push arrives:
  - Command still executes.
  - Echo is dropped and `echo_ovf` sets in the same cycle.
  - If a pop occurs in that same cycle, the push succeeds and `echo_ovf` stays unchanged.
- Push into an empty FIFO while IDLE: the byte is visible to the FSM the next cycle; there is no same-cycle bypass.
- `tx_done` in IDLE is ignored.
- `tx_done` in BUSY, with the FIFO non-empty: FSM returns to IDLE, and the next `tx_start` occurs one cycle later. Minimum spacing between `tx_start` pulses is 2 cycles after `tx_done`.
- Reset asserted mid-operation: every output returns to its reset value immediately and queued echoes are discarded. An in-flight `uart_tx` frame is not aborted by this block.
- `echo_ovf` clears only on reset.

## Structure
- Shared package `uart_cmd_pkg` holds:
  - the ASCII command constants (0x52, 0x43, 0x55, 0x44, 0x4E, 0x4D, 0x57, 0x48, 0x54, 0x50, 0x3F);
  - the `ascii_d` bit-index constants;
  - the TX FSM state encoding (IDLE=1'b0, BUSY=1'b1).
- One sub-module, `cmd_echo_fifo`:
  - ports: `push`, `din`, `pop`, `dout`, `full`, `empty`;
  - parameterised by `ECHO_DEPTH`.
- Decode logic and the TX FSM live in the top module.

## Test plan
- Reset, then `rx_done` with 0x52 → `ascii_d`=5'b00001 for exactly one cycle at n+1; `tx_start` at n+2 with `tx_data`=0x52.
- 0x6D ('m') twice, spaced 10 cycles → `ascii_up_down` goes 0→1→0; echoes are 0x4D, 0x4D.
- 0x41 ('A') → `ascii_d`=0 and no toggle changes; echo 0x3F.
- 6 bytes 'U' on consecutive cycles, `tx_done` withheld → six `ascii_d[2]` pulses; FIFO holds 4; `echo_ovf`=1. Then pulse `tx_done` four times → four `tx_start` pulses, each `tx_data`=0x55, and no further `tx_start`.
- FIFO full, with push and `tx_done`-driven pop in the same cycle → count stays 4 and `echo_ovf` does not newly set.
- Assert `reset` while BUSY with 3 queued → `tx_start`=0, toggles=0, `echo_ovf`=0. After release, no `tx_start` occurs without a new `rx_done`.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command decoder: command bytes, ascii_d bit
// positions, toggle-level bit positions and the TX FSM state encoding.
package uart_cmd_pkg;

   localparam logic [7:0] CMD_RUN     = 8'h52;  // 'R'
   localparam logic [7:0] CMD_CLEAR   = 8'h43;  // 'C'
   localparam logic [7:0] CMD_UP      = 8'h55;  // 'U'
   localparam logic [7:0] CMD_DOWN    = 8'h44;  // 'D'
   localparam logic [7:0] CMD_NEXT    = 8'h4E;  // 'N'
   localparam logic [7:0] CMD_MODE    = 8'h4D;  // 'M'
   localparam logic [7:0] CMD_WATCH   = 8'h57;  // 'W'
   localparam logic [7:0] CMD_HMS     = 8'h48;  // 'H'
   localparam logic [7:0] CMD_SET     = 8'h54;  // 'T'
   localparam logic [7:0] CMD_HUMI    = 8'h50;  // 'P'
   localparam logic [7:0] CMD_UNKNOWN = 8'h3F;  // '?'

   localparam int D_RUN   = 0;
   localparam int D_CLEAR = 1;
   localparam int D_UP    = 2;
   localparam int D_DOWN  = 3;
   localparam int D_NEXT  = 4;

   localparam int T_UP_DOWN   = 0;
   localparam int T_SW_WATCH  = 1;
   localparam int T_HM_SMS    = 2;
   localparam int T_WATCH_SET = 3;
   localparam int T_HUMI_TEMP = 4;

   typedef enum logic {
      TX_IDLE = 1'b0,
      TX_BUSY = 1'b1
   } tx_state_e;

   function automatic logic [7:0] fold_case(input logic [7:0] b);
      if (b >= 8'h61 && b <= 8'h7A) begin
         return b - 8'h20;
      end
      return b;
   endfunction

endpackage

// File: rtl/cmd_echo_fifo.sv
// Circular echo-byte FIFO with wrapping pointers and an occupancy counter.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module cmd_echo_fifo #(
   parameter int ECHO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic [7:0] din,
   input  logic       pop,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);

   // Depth must be a power of two (>= 2) so the pointers wrap for free.
   localparam int AW = $clog2(ECHO_DEPTH);

   logic [7:0]    mem_q [ECHO_DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic          do_push;
   logic          do_pop;

   assign full    = (count_q == (AW+1)'(ECHO_DEPTH));
   assign empty   = (count_q == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem_q[rd_ptr_q];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Decodes received UART bytes into command pulses and mode-toggle levels and
// queues an acknowledgement echo per byte for a one-frame-at-a-time TX FSM.
module uart_cmd_decoder
   import uart_cmd_pkg::*;
#(
   parameter int ECHO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_done,
   input  logic       tx_done,
   output logic       tx_start,
   output logic [7:0] tx_data,
   output logic [4:0] ascii_d,
   output logic       ascii_up_down,
   output logic       ascii_stopwatch_watch,
   output logic       ascii_hm_sms,
   output logic       ascii_watch_set,
   output logic       ascii_humi_temp,
   output logic       echo_ovf
);

   logic [7:0] folded;
   logic [7:0] echo_byte;
   logic [4:0] pulse_hit;
   logic [4:0] toggle_hit;
   logic [4:0] ascii_d_q;
   logic [4:0] toggle_q;
   logic       echo_ovf_q;
   logic       tx_start_q, tx_start_d;
   logic [7:0] tx_data_q, tx_data_d;
   tx_state_e  state_q, state_d;
   logic       fifo_full;
   logic       fifo_empty;
   logic       fifo_pop;
   logic [7:0] fifo_dout;

   always_comb begin
      folded     = fold_case(rx_data);
      pulse_hit  = '0;
      toggle_hit = '0;
      case (folded)
         CMD_RUN:   pulse_hit[D_RUN]         = 1'b1;
         CMD_CLEAR: pulse_hit[D_CLEAR]       = 1'b1;
         CMD_UP:    pulse_hit[D_UP]          = 1'b1;
         CMD_DOWN:  pulse_hit[D_DOWN]        = 1'b1;
         CMD_NEXT:  pulse_hit[D_NEXT]        = 1'b1;
         CMD_MODE:  toggle_hit[T_UP_DOWN]    = 1'b1;
         CMD_WATCH: toggle_hit[T_SW_WATCH]   = 1'b1;
         CMD_HMS:   toggle_hit[T_HM_SMS]     = 1'b1;
         CMD_SET:   toggle_hit[T_WATCH_SET]  = 1'b1;
         CMD_HUMI:  toggle_hit[T_HUMI_TEMP]  = 1'b1;
         default:   ;
      endcase
      echo_byte = (|{pulse_hit, toggle_hit}) ? folded : CMD_UNKNOWN;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ascii_d_q  <= '0;
         toggle_q   <= '0;
         echo_ovf_q <= 1'b0;
      end else begin
         ascii_d_q <= rx_done ? pulse_hit : '0;
         if (rx_done) toggle_q <= toggle_q ^ toggle_hit;
         // A full FIFO still accepts the echo if the FSM drains one this cycle.
         if (rx_done && fifo_full && !fifo_pop) echo_ovf_q <= 1'b1;
      end
   end

   cmd_echo_fifo #(
      .ECHO_DEPTH(ECHO_DEPTH)
   ) u_echo_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (rx_done),
      .din   (echo_byte),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign fifo_pop = (state_q == TX_IDLE) && !fifo_empty;

   always_comb begin
      state_d    = state_q;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      case (state_q)
         TX_IDLE: begin
            if (!fifo_empty) begin
               tx_start_d = 1'b1;
               tx_data_d  = fifo_dout;
               state_d    = TX_BUSY;
            end
         end
         TX_BUSY: begin
            if (tx_done) state_d = TX_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= TX_IDLE;
         tx_start_q <= 1'b0;
         tx_data_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
      end
   end

   assign ascii_d               = ascii_d_q;
   assign ascii_up_down         = toggle_q[T_UP_DOWN];
   assign ascii_stopwatch_watch = toggle_q[T_SW_WATCH];
   assign ascii_hm_sms          = toggle_q[T_HM_SMS];
   assign ascii_watch_set       = toggle_q[T_WATCH_SET];
   assign ascii_humi_temp       = toggle_q[T_HUMI_TEMP];
   assign echo_ovf              = echo_ovf_q;
   assign tx_start              = tx_start_q;
   assign tx_data               = tx_data_q;

endmodule
